// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_pkg
// Description : Shared types and defaults for the coin acceptor front end.
//               coin_t is the 2-bit code stored in the coin FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_N    = 2'b01,
    COIN_D    = 2'b10,
    COIN_Q    = 2'b11
  } coin_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_FIFO_DEPTH      = 4;
  localparam int NUM_LINES               = 3;

  // Sensor line index (0 = nickel, 1 = dime, 2 = quarter) to coin code.
  function automatic coin_t coin_of_line(input logic [1:0] idx);
    case (idx)
      2'd0:    return COIN_N;
      2'd1:    return COIN_D;
      2'd2:    return COIN_Q;
      default: return COIN_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
// Module      : coin_debounce
// Description : 2-FF synchronizer, debounce counter and rising-edge detect
//               for one raw coin sensor line.
// Ports       : clk      - system clock
//               reset    - asynchronous active-low reset
//               raw_i    - asynchronous, possibly bouncing sensor line
//               stable_o - debounced level
//               rise_o   - high for one cycle after stable_o goes 0->1
// Revision    : 1.0 - initial release
// ============================================================================
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [7:0] CNT_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q;
  logic       sync2_q;
  logic       stable_q;
  logic       stable_d;
  logic       stable_prev_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Counter clears on agreement and on the flip itself, so a flip needs
  // DEBOUNCE_CYCLES uninterrupted disagreeing samples.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q + 8'd1 == CNT_LIMIT) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= raw_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~stable_prev_q;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Conditions three coin sensor lines, arbitrates coin events
//               into a small FIFO and pops one coin per ready cycle as a
//               one-hot N/D/Q pulse. Colliding or overflowing coins pulse
//               reject.
// Ports       : clk                 - system clock
//               reset               - asynchronous active-low reset
//               raw_n/raw_d/raw_q   - raw coin sensors
//               ready               - downstream can take a coin this cycle
//               N/D/Q               - registered one-cycle coin pulses
//               reject              - registered one-cycle reject pulse
//               jam                 - two or more lines stable-high
//               count               - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        raw_n,
  input  logic                        raw_d,
  input  logic                        raw_q,
  input  logic                        ready,
  output logic                        N,
  output logic                        D,
  output logic                        Q,
  output logic                        reject,
  output logic                        jam,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [NUM_LINES-1:0] w_raw;
  logic [NUM_LINES-1:0] w_stable;
  logic [NUM_LINES-1:0] w_rise;

  assign w_raw = {raw_q, raw_d, raw_n};

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (w_raw[gi]),
        .stable_o (w_stable[gi]),
        .rise_o   (w_rise[gi])
      );
    end
  endgenerate

  coin_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_n_q, out_n_d;
  logic             out_d_q, out_d_d;
  logic             out_q_q, out_q_d;
  logic             reject_q, reject_d;
  logic             jam_q, jam_d;

  logic [1:0]       w_num_events;
  coin_t            w_push_code;
  coin_t            w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  assign w_head = mem_q[rd_ptr_q];

  always_comb begin
    w_num_events = 2'(w_rise[0]) + 2'(w_rise[1]) + 2'(w_rise[2]);
    w_push_code  = COIN_NONE;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (w_rise[i]) begin
        w_push_code = coin_of_line(2'(i));
      end
    end

    w_full   = (count_q == FULL_COUNT);
    w_pop    = (count_q != '0) && ready;
    w_push   = 1'b0;
    reject_d = 1'b0;

    // A pop in the same cycle frees the slot a single event needs.
    if (w_num_events == 2'd1) begin
      if (!w_full || w_pop) begin
        w_push = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end else if (w_num_events >= 2'd2) begin
      reject_d = 1'b1;
    end

    wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end

    out_n_d = w_pop && (w_head == COIN_N);
    out_d_d = w_pop && (w_head == COIN_D);
    out_q_d = w_pop && (w_head == COIN_Q);

    jam_d = (w_stable[0] & w_stable[1]) | (w_stable[0] & w_stable[2]) |
            (w_stable[1] & w_stable[2]);
  end

  // Storage needs no reset: entries are only read when count_q says valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_push_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_n_q  <= 1'b0;
      out_d_q  <= 1'b0;
      out_q_q  <= 1'b0;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_n_q  <= out_n_d;
      out_d_q  <= out_d_d;
      out_q_q  <= out_q_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
    end
  end

  assign N      = out_n_q;
  assign D      = out_d_q;
  assign Q      = out_q_q;
  assign reject = reject_q;
  assign jam    = jam_q;
  assign count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Scoreboard bench for coin_acceptor. A behavioural model
//               predicts output pulses, occupancy and jam; a monitor
//               compares the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic raw_n  = 1'b0;
  logic raw_d  = 1'b0;
  logic raw_q  = 1'b0;
  logic ready  = 1'b0;
  logic N, D, Q, reject, jam;
  logic [$clog2(DEPTH):0] count;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_n  (raw_n),
    .raw_d  (raw_d),
    .raw_q  (raw_q),
    .ready  (ready),
    .N      (N),
    .D      (D),
    .Q      (Q),
    .reject (reject),
    .jam    (jam),
    .count  (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [3:0] v;   // {reject, Q, D, N}
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mq[$];          // coin codes waiting to be delivered
  int         cyc = 0;
  logic [2:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_stp = '0;
  int         last_agree[3] = '{0, 0, 0};
  logic       m_jam = 1'b0;

  always @(negedge reset) begin
    sb.delete();
    mq.delete();
    m_s1 = '0; m_s2 = '0; m_st = '0; m_stp = '0; m_jam = 1'b0;
    for (int i = 0; i < 3; i++) last_agree[i] = cyc;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset) begin : model_step
      logic [2:0] ev;
      int         nev;
      bit         pop, full;
      logic [3:0] v;
      int         c;
      ev   = m_st & ~m_stp;
      nev  = $countones(ev);
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && ready;
      v    = '0;
      if (pop) begin
        c = int'(mq.pop_front());
        v[c-1] = 1'b1;
      end
      if (nev == 1) begin
        if (!full || pop) begin
          for (int i = 0; i < 3; i++) if (ev[i]) c = i + 1;
          mq.push_back(2'(c));
        end else begin
          v[3] = 1'b1;
        end
      end else if (nev > 1) begin
        v[3] = 1'b1;
      end
      if (v != '0) sb.push_back('{cyc, v});
      m_jam = ($countones(m_st) >= 2);
      m_stp = m_st;
      // A line flips once its synchronized value has disagreed for DEB edges.
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] == m_st[i]) begin
          last_agree[i] = cyc;
        end else if (cyc - last_agree[i] >= DEB) begin
          m_st[i] = m_s2[i];
          last_agree[i] = cyc;
        end
      end
      m_s2 = m_s1;
      m_s1 = {raw_q, raw_d, raw_n};
    end
  end

  // ---------------- monitor ----------------
  int n_cnt = 0, d_cnt = 0, q_cnt = 0, rej_cnt = 0, last_n_cyc = -1;
  bit jam_seen = 1'b0;

  always @(negedge clk) begin
    if (reset) begin : mon_step
      logic [3:0] dv;
      exp_t       e;
      dv = {reject, Q, D, N};
      chk("count", 32'(count), 32'(mq.size()));
      chk("jam", 32'(jam), 32'(m_jam));
      chk("onehot", 32'(N + D + Q <= 2'd1), 32'd1);
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        chk("sb_missed", 32'd0, 32'(sb[0].v));
        void'(sb.pop_front());
      end
      if (dv != '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 32'(dv), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_cycle", 32'(cyc), 32'(e.cyc));
          chk("sb_value", 32'(dv), 32'(e.v));
        end
      end
      if (N) begin n_cnt++; last_n_cyc = cyc; end
      if (D) d_cnt++;
      if (Q) q_cnt++;
      if (reject) rej_cnt++;
      if (jam) jam_seen = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic coin(input int line, input int hi, input int lo);
    {raw_q, raw_d, raw_n} = 3'(1 << line);
    cycles(hi);
    {raw_q, raw_d, raw_n} = 3'b000;
    cycles(lo);
  endtask

  int n0, d0, q0, r0, k;

  initial begin
    #1 reset = 1'b0;
    cycles(3);
    chk("rst_N", 32'(N), 0);
    chk("rst_D", 32'(D), 0);
    chk("rst_Q", 32'(Q), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_jam", 32'(jam), 0);
    chk("rst_count", 32'(count), 0);
    reset = 1'b1;
    cycles(3);

    // 1: clean nickel
    ready = 1'b1;
    n0 = n_cnt; r0 = rej_cnt;
    raw_n = 1'b1;
    k = cyc + 1;
    cycles(20);
    raw_n = 1'b0;
    cycles(12);
    chk("t1_n_pulses", 32'(n_cnt - n0), 1);
    chk("t1_n_cycle", 32'(last_n_cyc), 32'(k + DEB + 3));
    chk("t1_reject", 32'(rej_cnt - r0), 0);
    chk("t1_count", 32'(count), 0);

    // 2: bouncing dime
    n0 = n_cnt; d0 = d_cnt; q0 = q_cnt;
    for (int i = 0; i < 6; i++) begin
      raw_d = ~raw_d;
      cycles(2);
    end
    raw_d = 1'b1;
    cycles(10);
    raw_d = 1'b0;
    cycles(12);
    chk("t2_d_pulses", 32'(d_cnt - d0), 1);
    chk("t2_nq_pulses", 32'(n_cnt - n0 + q_cnt - q0), 0);

    // 3: simultaneous nickel and quarter
    n0 = n_cnt; q0 = q_cnt; r0 = rej_cnt; jam_seen = 1'b0;
    raw_n = 1'b1; raw_q = 1'b1;
    cycles(12);
    raw_n = 1'b0; raw_q = 1'b0;
    cycles(12);
    chk("t3_reject", 32'(rej_cnt - r0), 1);
    chk("t3_jam_seen", 32'(jam_seen), 1);
    chk("t3_nq_pulses", 32'(n_cnt - n0 + q_cnt - q0), 0);
    chk("t3_count", 32'(count), 0);

    // 4: backpressure overflow then drain
    ready = 1'b0;
    q0 = q_cnt; r0 = rej_cnt;
    for (int i = 0; i < 5; i++) coin(2, 8, 7);
    chk("t4_count_full", 32'(count), 4);
    chk("t4_reject", 32'(rej_cnt - r0), 1);
    ready = 1'b1;
    cycles(6);
    chk("t4_q_pulses", 32'(q_cnt - q0), 4);
    chk("t4_count", 32'(count), 0);

    // 5: dime event evaluated on the edge ready rises with the FIFO full
    ready = 1'b0;
    d0 = d_cnt; q0 = q_cnt;
    for (int i = 0; i < 4; i++) coin(2, 8, 7);
    chk("t5_count_full", 32'(count), 4);
    r0 = rej_cnt;
    raw_d = 1'b1;
    cycles(DEB + 2);
    ready = 1'b1;
    cycles(1);
    chk("t5_count_hold", 32'(count), 4);
    chk("t5_reject", 32'(rej_cnt - r0), 0);
    raw_d = 1'b0;
    cycles(12);
    chk("t5_count", 32'(count), 0);
    chk("t5_q_pulses", 32'(q_cnt - q0), 4);
    chk("t5_d_pulses", 32'(d_cnt - d0), 1);

    // 6: reset mid-operation discards queued coins
    ready = 1'b0;
    coin(0, 8, 7);
    coin(1, 8, 7);
    coin(2, 8, 7);
    chk("t6_count_queued", 32'(count), 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_N", 32'(N), 0);
    chk("t6_D", 32'(D), 0);
    chk("t6_Q", 32'(Q), 0);
    chk("t6_reject", 32'(reject), 0);
    chk("t6_jam", 32'(jam), 0);
    chk("t6_count", 32'(count), 0);
    cycles(2);
    reset = 1'b1;
    ready = 1'b1;
    n0 = n_cnt; d0 = d_cnt; q0 = q_cnt;
    cycles(20);
    chk("t6_no_pulses", 32'(n_cnt - n0 + d_cnt - d0 + q_cnt - q0), 0);

    // random episodes: bounce, optional collisions, random backpressure
    for (int ep = 0; ep < 40; ep++) begin
      logic [2:0] m;
      int         b, hi, lo;
      m  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7))
                                       : 3'(1 << $urandom_range(0, 2));
      b  = $urandom_range(0, 6);
      hi = $urandom_range(5, 10);
      lo = $urandom_range(6, 12);
      for (int i = 0; i < b; i++) begin
        {raw_q, raw_d, raw_n} = 3'($urandom) & m;
        ready = 1'($urandom);
        cycles(1);
      end
      {raw_q, raw_d, raw_n} = m;
      for (int i = 0; i < hi; i++) begin
        ready = 1'($urandom);
        cycles(1);
      end
      {raw_q, raw_d, raw_n} = 3'b000;
      for (int i = 0; i < lo; i++) begin
        ready = ($urandom_range(0, 3) != 0);
        cycles(1);
      end
    end

    ready = 1'b1;
    cycles(30);
    chk("end_sb_empty", 32'(sb.size()), 0);
    chk("end_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
